// File: rtl/fragment_writer_if.sv
// Fragment stream types and the fragment/memory bus bundle used by fragment_writer.
// master = the writer side (fragment sink, memory requester); slave = the environment side.
package fragment_pkg;
  typedef logic signed [31:0] fp32_t;
  localparam fp32_t FP_ONE = 32'sh0001_0000;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    fp32_t       z;
    fp32_t       u;
    fp32_t       v;
    fp32_t       r;
    fp32_t       g;
    fp32_t       b;
    logic        valid;
  } fragment_t;
endpackage

interface fragment_writer_if
  import fragment_pkg::*;
#(
  parameter int ADDR_W = 20
);
  fragment_t         frag_in;
  logic              frag_valid;
  logic              frag_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    input  frag_in, frag_valid, mem_rdata, mem_ack,
    output frag_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output frag_in, frag_valid, mem_rdata, mem_ack,
    input  frag_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fragment_writer.sv
// Fragment writer: bounds check, RGB565 pack and framebuffer write over a req/ack bus.
// Optional depth test (read-compare-write of a 16-bit depth buffer) enabled by DEPTH_TEST_EN.
module fragment_writer
  import fragment_pkg::*;
#(
  parameter int                FB_WIDTH   = 640,
  parameter int                FB_HEIGHT  = 480,
  parameter int                ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] COLOR_BASE = 20'h00000,
  parameter logic [ADDR_W-1:0] DEPTH_BASE = 20'h4B000
) (
  input  logic               clk,
  input  logic               rst_n,
  fragment_writer_if.master  bus,
  output logic [31:0]        pix_written,
  output logic [31:0]        pix_killed,
  output logic               idle
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEPTH_RD = 2'd1,
    DEPTH_WR = 2'd2,
    COLOR_WR = 2'd3
  } state_t;

  function automatic logic [7:0] chan8(input fp32_t c);
    logic [7:0] res;
    if (c[31]) begin
      res = 8'h00;
    end else if (c >= FP_ONE) begin
      res = 8'hFF;
    end else begin
      res = c[15:8];
    end
    return res;
  endfunction

  function automatic logic [15:0] pack565(input fp32_t r, input fp32_t g, input fp32_t b);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    r8 = chan8(r);
    g8 = chan8(g);
    b8 = chan8(b);
    return {r8[7:3], g8[7:2], b8[7:3]};
  endfunction

`ifdef DEPTH_TEST_EN
  function automatic logic [15:0] depth_conv(input fp32_t z);
    logic [15:0] res;
    if (z[31]) begin
      res = 16'h0000;
    end else if (z >= FP_ONE) begin
      res = 16'hFFFF;
    end else begin
      res = z[15:0];
    end
    return res;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       color_q, color_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       pix_written_q, pix_written_d;
  logic [31:0]       pix_killed_q, pix_killed_d;
`ifdef DEPTH_TEST_EN
  logic [15:0]       depth_q, depth_d;
`endif

  logic        accept_s;
  logic        oob_s;
  logic        ack_s;
  logic        written_inc_s;
  logic        killed_inc_s;
  logic [31:0] idx_full_s;

  assign accept_s   = bus.frag_valid && (state_q == IDLE);
  assign oob_s      = ({16'h0000, bus.frag_in.x} >= 32'(FB_WIDTH)) ||
                      ({16'h0000, bus.frag_in.y} >= 32'(FB_HEIGHT));
  assign ack_s      = mem_req_q && bus.mem_ack;
  assign idx_full_s = ({16'h0000, bus.frag_in.y} * 32'(FB_WIDTH)) + {16'h0000, bus.frag_in.x};

  // Next-state, latch and counter logic; memory outputs are derived from the next state
  // so that mem_req is already high in the first cycle of every memory state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    color_d       = color_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    written_inc_s = 1'b0;
    killed_inc_s  = 1'b0;
`ifdef DEPTH_TEST_EN
    depth_d       = depth_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_s && oob_s) begin
          killed_inc_s = 1'b1;
        end else if (accept_s) begin
          idx_d   = ADDR_W'(idx_full_s);
          color_d = pack565(bus.frag_in.r, bus.frag_in.g, bus.frag_in.b);
`ifdef DEPTH_TEST_EN
          depth_d = depth_conv(bus.frag_in.z);
          state_d = DEPTH_RD;
`else
          state_d = COLOR_WR;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef DEPTH_TEST_EN
      DEPTH_RD: begin
        if (ack_s && (depth_q < bus.mem_rdata)) begin
          state_d = DEPTH_WR;
        end else if (ack_s) begin
          state_d      = IDLE;
          killed_inc_s = 1'b1;
        end else begin
          state_d = DEPTH_RD;
        end
      end
      DEPTH_WR: begin
        if (ack_s) begin
          state_d = COLOR_WR;
        end else begin
          state_d = DEPTH_WR;
        end
      end
`endif
      COLOR_WR: begin
        if (ack_s) begin
          state_d       = IDLE;
          written_inc_s = 1'b1;
        end else begin
          state_d = COLOR_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      IDLE: begin
        mem_req_d = 1'b0;
      end
`ifdef DEPTH_TEST_EN
      DEPTH_RD: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = DEPTH_BASE + idx_d;
      end
      DEPTH_WR: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = DEPTH_BASE + idx_d;
        mem_wdata_d = depth_d;
      end
`endif
      COLOR_WR: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = COLOR_BASE + idx_d;
        mem_wdata_d = color_d;
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase

    if (written_inc_s && (pix_written_q != 32'hFFFF_FFFF)) begin
      pix_written_d = pix_written_q + 32'd1;
    end else begin
      pix_written_d = pix_written_q;
    end
    if (killed_inc_s && (pix_killed_q != 32'hFFFF_FFFF)) begin
      pix_killed_d = pix_killed_q + 32'd1;
    end else begin
      pix_killed_d = pix_killed_q;
    end
  end

  // State, latched fragment, registered bus outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      color_q       <= 16'h0000;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 16'h0000;
      pix_written_q <= 32'h0000_0000;
      pix_killed_q  <= 32'h0000_0000;
`ifdef DEPTH_TEST_EN
      depth_q       <= 16'h0000;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      color_q       <= color_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      pix_written_q <= pix_written_d;
      pix_killed_q  <= pix_killed_d;
`ifdef DEPTH_TEST_EN
      depth_q       <= depth_d;
`endif
    end
  end

  assign bus.frag_ready = (state_q == IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign pix_written    = pix_written_q;
  assign pix_killed     = pix_killed_q;
  assign idle           = (state_q == IDLE);

endmodule

// File: doc/fragment_writer.md
Name: fragment_writer

Overview:
- Downstream consumer of the rasterizer's fragment stream: accepts fragment_t over valid/ready.
- Bounds-checks each fragment against the framebuffer; optional depth test.
- Packs colour to RGB565 and writes pixel and depth words to a shared 16-bit memory over a req/ack bus.
- Sits between the rasterizer and the framebuffer/SDRAM arbiter; one fragment in flight at a time.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels
FB_HEIGHT, 480, framebuffer height in pixels
ADDR_W, 20, memory word-address width
COLOR_BASE, 20'h00000, word address of colour buffer pixel (0,0)
DEPTH_BASE, 20'h4B000, word address of depth buffer pixel (0,0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frag_in  in  fragment_t  fragment from rasterizer (x, y, z, u, v, r, g, b, valid)
frag_valid  in  1  fragment present
frag_ready  out  1  writer can accept a fragment this cycle
mem_req  out  1  memory request, held until acked
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word address
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid in the ack cycle of a read
mem_ack  in  1  completes the request in the cycle mem_req && mem_ack
pix_written  out  32  count of colour writes
pix_killed  out  32  count of discarded fragments (bounds or depth fail)
idle  out  1  state == IDLE

Behaviour:
- Reset: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0. frag_ready=1, idle=1 after reset. Reset mid-transaction aborts it immediately, mem_req drops asynchronously, and the latched fragment is lost.
- frag_ready = (state == IDLE). A fragment is accepted on frag_valid && frag_ready.
- Accept-time bounds check: x >= FB_WIDTH or y >= FB_HEIGHT (unsigned) means discard. State stays IDLE, pix_killed increments, and frag_ready stays high, so back-to-back kills run at 1 per cycle.
- In-bounds fragments are latched; the following are registered at accept:
  - pixel index = y*FB_WIDTH + x
  - colour565
  - depth16
- Colour conversion: each channel is a Q16.16 fp32_t.
  - Negative -> 0; >= FP_ONE -> 255; else bits [15:8].
  - Packed as {r8[7:3], g8[7:2], b8[7:3]}.
- Depth conversion: z negative -> 16'h0000; z >= FP_ONE -> 16'hFFFF; else z[15:0].
- Addresses: COLOR_BASE+index or DEPTH_BASE+index, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- States: IDLE, DEPTH_RD, DEPTH_WR, COLOR_WR.
  - IDLE -> COLOR_WR on in-bounds accept (DEPTH_RD when depth test compiled in).
  - DEPTH_RD: mem_req=1, mem_we=0, addr=depth address. On ack, compare: depth16 < mem_rdata -> DEPTH_WR; else -> IDLE and pix_killed++. Equal fails.
  - DEPTH_WR: write depth16 to depth address; on ack -> COLOR_WR.
  - COLOR_WR: write colour565 to colour address; on ack -> IDLE and pix_written++.
- mem_req asserts in the cycle after entering a memory state is registered (i.e. the first cycle in that state). mem_we/mem_addr/mem_wdata stay stable while mem_req is high.
- mem_req deasserts the cycle after the ack unless the next state also requests; then it stays high with the new address/data.
- Zero-wait memory (ack in the first req cycle) gives minimum occupancy:
  - 1 cycle accept + 1 per memory op.
  - Colour-only: fragment accepted at T, write at T+1, frag_ready high at T+2.
- mem_ack while mem_req=0 is ignored.
- Counters saturate at 32'hFFFF_FFFF.
- A depth-kill and a bounds-kill never coincide (single fragment in flight).

Optional Feature:
- DEPTH_TEST_EN defined: DEPTH_RD/DEPTH_WR path as above; 3 memory ops per passing fragment.
- DEPTH_TEST_EN undefined:
  - DEPTH_RD and DEPTH_WR logic is not built; IDLE goes straight to COLOR_WR.
  - DEPTH_BASE is unused and depth16 is not computed.
  - Only bounds kills increment pix_killed.

Test Plan:
- Zero-wait ack, depth off: fragment x=3,y=2, r=g=b=FP_ONE -> one write, addr 20'h00503 (2*640+3), wdata 16'hFFFF; pix_written=1; frag_ready low for exactly 1 cycle.
- Bounds kill: x=640,y=0 then x=0,y=480 on consecutive cycles -> no mem_req, pix_killed=2, frag_ready never drops.
- Colour clamp/pack: r=-FP_ONE, g=0x0000_8000 (0.5), b=0x0002_0000 (2.0) -> wdata 16'h041F (r5=0, g6=0x20, b5=0x1F).
- Depth on, memory returns 16'h8000: z=0x0000_4000 -> read 20'h4B000+idx, write 16'h4000 to depth, then colour write. Same fragment with z=0x0000_8000 (equal) -> killed, pix_killed++, no writes.
- Wait states: ack delayed 5 cycles on every op -> mem_addr/mem_wdata/mem_we stable throughout; frag_ready low until the final ack+1; no fragment lost under continuous frag_valid.
- Async reset asserted during DEPTH_WR -> mem_req low immediately, idle=1, counters 0; the next fragment is processed normally.
